// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shifter: mode encoding and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_ROTR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Single combinational shift stage: moves the accumulator by 0..MAX_STEP
// positions in the requested mode. SRA fills with the externally supplied
// sign so the fill stays that of the original operand across iterations.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_STEP = 4,
    parameter int STEP_W   = $clog2(MAX_STEP + 1)
) (
    input  logic [WIDTH-1:0]  acc,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic              sign,
    output logic [WIDTH-1:0]  result
);

    // Select the shifted word for the current mode.
    always_comb begin
        // NOTE: every path assigns result (default first), so no latch is inferred.
        result = acc;
        case (shift_mode_e'(mode))
            SHIFT_SLL:  result = acc << step;
            SHIFT_SRL:  result = acc >> step;
            // Shift a sign-extended double word and keep the low half.
            SHIFT_SRA:  result = WIDTH'({{WIDTH{sign}}, acc} >> step);
            // Bits leaving the LSB come back in at the MSB.
            SHIFT_ROTR: result = WIDTH'({acc, acc} >> step);
            default:    result = acc;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: accepts an operand in IDLE, shifts it at most
// MAX_STEP bits per clock in SHIFT, and holds the result in DONE until
// writeback takes it. All handshake outputs decode registered state only.
module shift_unit
    import shift_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int MAX_STEP = 4,
    localparam int SHAMT_W  = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    localparam int STEP_W = $clog2(MAX_STEP + 1);

    state_e             state;
    state_e             state_next;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_shifted;
    logic [SHAMT_W-1:0] remaining;
    logic [SHAMT_W-1:0] remaining_next;
    logic [STEP_W-1:0]  step;
    shift_mode_e        mode;
    logic               sign;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (in_shamt != '0) ? SHIFT : DONE;
            SHIFT:   if (remaining_next == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs, decoded from registered state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Step size this cycle: min(remaining, MAX_STEP), and what is left after it.
    // remaining never exceeds WIDTH-1, so the narrowing casts are lossless.
    always_comb begin
        if (int'(remaining) >= MAX_STEP) step = STEP_W'(MAX_STEP);
        else                             step = STEP_W'(remaining);
        remaining_next = remaining - SHAMT_W'(step);
    end

    shift_step #(
        .WIDTH    (WIDTH),
        .MAX_STEP (MAX_STEP),
        .STEP_W   (STEP_W)
    ) u_step (
        .acc    (acc),
        .step   (step),
        .mode   (mode),
        .sign   (sign),
        .result (acc_shifted)
    );

    // Datapath: latch the request in IDLE, iterate in SHIFT, hold in DONE.
    always_ff @(posedge clk) begin
        // NOTE: the accumulator is reset because it drives out_data, which must read 0 after reset.
        if (reset) begin
            acc       <= '0;
            remaining <= '0;
            mode      <= SHIFT_SLL;
            sign      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc       <= in_data;
                        remaining <= in_shamt;
                        mode      <= shift_mode_e'(in_mode);
                        sign      <= in_data[WIDTH-1];
                    end
                end
                SHIFT: begin
                    acc       <= acc_shifted;
                    remaining <= remaining_next;
                end
                default: ;
            endcase
        end
    end

    assign out_data = acc;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (WIDTH=32, MAX_STEP=4) with a randomized
// back-to-back run checked against a behavioural shift model.
module tb_shift_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [1:0] M_SLL  = 2'b00;
    localparam logic [1:0] M_SRL  = 2'b01;
    localparam logic [1:0] M_SRA  = 2'b10;
    localparam logic [1:0] M_ROTR = 2'b11;

    shift_unit #(.WIDTH(32), .MAX_STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge (caller ensures in_ready is high).
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called at cycle T+1; checks out_valid first rises at T+exp_lat with exp_data.
    task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_data);
        int lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, exp_data);
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ready_after_handoff"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic [1:0] m);
        logic signed [31:0] sd;
        sd = d;
        case (m)
            M_SLL:   return d << s;
            M_SRL:   return d >> s;
            M_SRA:   return sd >>> s;
            default: return (d >> s) | (d << (32 - s));
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", out_data, 32'h0);

        // 1: SLL 1 by 2
        send(32'h0000_0001, 5'd2, M_SLL);
        chk("t1_busy_T1", 32'(busy), 32'd1);
        wait_result("t1", 2, 32'h0000_0004);
        chk("t1_busy_T2", 32'(busy), 32'd1);
        handoff("t1");
        chk("t1_busy_after", 32'(busy), 32'd0);

        // 2: SRA / SRL of 0x80000000 by 31 (8 SHIFT cycles)
        send(32'h8000_0000, 5'd31, M_SRA);
        wait_result("t2_sra", 9, 32'hFFFF_FFFF);
        handoff("t2_sra");
        send(32'h8000_0000, 5'd31, M_SRL);
        wait_result("t2_srl", 9, 32'h0000_0001);
        handoff("t2_srl");

        // 3: ROTR by 8, SLL all-ones by 31
        send(32'h1234_5678, 5'd8, M_ROTR);
        wait_result("t3_rotr", 3, 32'h7812_3456);
        handoff("t3_rotr");
        send(32'hFFFF_FFFF, 5'd31, M_SLL);
        wait_result("t3_sll", 9, 32'h8000_0000);
        handoff("t3_sll");

        // 4: zero shift, then backpressure with ignored requests
        send(32'hDEAD_BEEF, 5'd0, M_SRA);
        wait_result("t4", 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0BAD_0000 + 32'(i);
            in_shamt = 5'd5;
            in_mode  = M_SLL;
            tick();
            chk("t4_hold_out_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
            chk("t4_hold_data", out_data, 32'hDEAD_BEEF);
        end
        in_valid = 1'b0;
        handoff("t4");
        chk("t4_busy_after", 32'(busy), 32'd0);
        chk("t4_data_after", out_data, 32'hDEAD_BEEF);

        // 5: reset during the 2nd SHIFT cycle of SRL by 20
        send(32'hF000_0000, 5'd20, M_SRL);
        tick();
        chk("t5_busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_out_data", out_data, 32'h0);
        tick();
        chk("t5_stays_idle", 32'(busy), 32'd0);
        send(32'h0000_0001, 5'd1, M_SLL);
        wait_result("t5_after", 2, 32'h0000_0002);
        handoff("t5_after");

        // 6: back-to-back random traffic with in_valid and out_ready held high
        begin
            int          done_cnt = 0;
            int          cyc      = 0;
            int          lat      = 0;
            int          exp_lat  = 0;
            logic [31:0] exp_q    = '0;
            logic        prev_ov  = 1'b0;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            while (done_cnt < 1000 && cyc < 20000) begin
                if (prev_ov) chk("t6_ready_after_handoff", 32'(in_ready), 32'd1);
                if (out_valid) begin
                    chk("t6_data", out_data, exp_q);
                    chk("t6_latency", 32'(lat), 32'(exp_lat));
                    done_cnt++;
                end
                in_data  = $urandom;
                in_shamt = 5'($urandom_range(0, 31));
                in_mode  = 2'($urandom_range(0, 3));
                if (in_ready) begin
                    exp_q   = model(in_data, int'(in_shamt), in_mode);
                    exp_lat = (in_shamt == 0) ? 1 : (int'(in_shamt) + 3) / 4 + 1;
                    lat     = 0;
                end
                prev_ov = out_valid;
                tick();
                cyc++;
                lat++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("t6_results_seen", 32'(done_cnt), 32'd1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised multi-cycle shifter for the multicycle datapath. It performs logical-left, logical-right, arithmetic-right and rotate-right shifts on a WIDTH-bit operand by a variable amount, applying at most MAX_STEP bit positions per clock. Operands enter through a valid/ready handshake from the decode/ALU control. Results leave through a second valid/ready handshake toward writeback, which may apply backpressure.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- MAX_STEP, 4, maximum bit positions shifted per cycle; power of two, 1 ≤ MAX_STEP ≤ WIDTH
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived; not overridden)

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand request valid
- in_ready  out  1  unit can accept a request; high only in IDLE
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount, 0..WIDTH-1
- in_mode  in  2  shift mode (encoding in Structure)
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid, latch in_data into an accumulator, in_shamt into a remaining counter, and in_mode.
  - Go to SHIFT if in_shamt ≠ 0; otherwise go to DONE.
- **SHIFT**
  - Each cycle: step = min(remaining, MAX_STEP).
  - Shift the accumulator by step per the latched mode; remaining -= step.
  - Go to DONE when the new remaining = 0.
- **DONE**
  - out_valid = 1 and out_data = accumulator, held stable.
  - Go to IDLE on out_ready.
  - New requests are not accepted in the same cycle (in_ready = 0).
- **Mode semantics**
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the latched bit WIDTH-1 of the original operand.
  - ROTR: bits shifted out at the LSB re-enter at the MSB.
- All arithmetic is modulo WIDTH. No shift ever exceeds WIDTH-1 in total.
- in_valid while busy is ignored. No request is stored or queued.
- Input signals other than in_valid are don't-care outside IDLE.
- **Reset**, at any state including mid-SHIFT or while DONE awaits out_ready:
  - next state IDLE; accumulator, counter and mode cleared.
  - out_data = 0, out_valid = 0, busy = 0, in_ready = 1 after the edge.
  - Any in-flight result is discarded.

## Timing
- Request accepted at edge T means in_valid & in_ready were high at T.
- shamt = 0: out_valid is high in the cycle after T.
- shamt = s > 0: SHIFT lasts ceil(s / MAX_STEP) cycles, and out_valid is first high ceil(s / MAX_STEP) + 1 cycles after T.
- Result handed off at the edge where out_valid & out_ready are both high. in_ready is high from the following cycle.
- The earliest next accept is one cycle after handoff. Throughput is therefore one result per (latency + 1) cycles minimum.
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from inputs.
- out_data is the registered accumulator.

## Structure
- Package shift_pkg:
  - mode encoding SHIFT_SLL = 2'b00, SHIFT_SRL = 2'b01, SHIFT_SRA = 2'b10, SHIFT_ROTR = 2'b11.
  - FSM state typedef (IDLE/SHIFT/DONE).
- Sub-module shift_step:
  - purely combinational single-stage shifter.
  - inputs: accumulator, step (0..MAX_STEP), mode, sign bit.
  - output: the shifted word.
  - Instantiated once in shift_unit.
- Top-level shift_unit holds the FSM, accumulator, remaining counter, latched mode and sign.

## Test plan
All scenarios use WIDTH = 32, MAX_STEP = 4.
1. SLL 0x00000001 by 2, accepted at T -> out_data 0x00000004, out_valid first high at T+2, busy high T+1..T+2.
2. SRA 0x80000000 by 31 -> 0xFFFFFFFF, with 8 SHIFT cycles and out_valid at T+9. SRL of the same operand and amount -> 0x00000001.
3. ROTR 0x12345678 by 8 -> 0x78123456 at T+3. SLL 0xFFFFFFFF by 31 -> 0x80000000.
4. shamt = 0, mode SRA, operand 0xDEADBEEF -> out_valid at T+1 with out_data 0xDEADBEEF. Then hold out_ready = 0 for 3 cycles: out_data stays stable, in_ready = 0, and in_valid pulses are ignored.
5. Assert reset in the 2nd SHIFT cycle of an SRL by 20 -> next cycle state IDLE, out_valid 0, out_data 0, in_ready 1. A following SLL 0x1 by 1 -> 0x00000002 at T+2.
6. Back-to-back requests with in_valid held high and out_ready held high -> each new accept occurs exactly one cycle after the previous handoff, and results match a reference model over 1,000 random mode/operand/shamt triples.
